// File: rtl/tetris_input_conditioner_if.sv
// Button/ack/event bundle between the board, the conditioner and the CPU.
// The slave side belongs to the conditioner; master is the environment.
interface tetris_input_conditioner_if;
  logic [3:0] btn_n;
  logic [3:0] ack;
  logic [3:0] evt;
  logic [3:0] lost;
  logic [3:0] level;

  modport master (
    output btn_n,
    output ack,
    input  evt,
    input  lost,
    input  level
  );

  modport slave (
    input  btn_n,
    input  ack,
    output evt,
    output lost,
    output level
  );
endinterface

// File: rtl/tetris_input_conditioner.sv
// Four-button synchronizer, debouncer and sticky press/repeat event flags.
// Auto-repeat is built only when TETRIS_INPUT_REPEAT_EN is defined.
module tetris_input_conditioner #(
  parameter int         DEBOUNCE_CYCLES     = 500000,
  parameter int         REPEAT_DELAY_CYCLES = 10000000,
  parameter int         REPEAT_RATE_CYCLES  = 2500000,
  parameter logic [3:0] REPEAT_MASK         = 4'b0111,
  parameter int         CNT_W               = 24
) (
  input logic                         clock,
  input logic                         reset,
  tetris_input_conditioner_if.slave   bus
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef TETRIS_INPUT_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    HOLD   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd3
  } state_t;

  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_MASK,
                               REPEAT_DELAY_CYCLES[0],
                               REPEAT_RATE_CYCLES[0]};
`endif

  logic [3:0] sync1_n;
  logic [3:0] sync2_n;
  logic [3:0] s;
  logic [3:0] evt_v;
  logic [3:0] lost_v;
  logic [3:0] level_v;

  // Two-flop synchronizer; flops hold the active-low pin so reset = released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_n <= 4'hF;
      sync2_n <= 4'hF;
    end else begin
      sync1_n <= bus.btn_n;
      sync2_n <= sync1_n;
    end
  end

  assign s = ~sync2_n;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             clean_q;
    logic             clean_d;
    state_t           st_q;
    state_t           st_d;
    logic             fire;
    logic             evt_q;
    logic             evt_d;
    logic             lost_q;
    logic             lost_d;
`ifdef TETRIS_INPUT_REPEAT_EN
    logic [CNT_W-1:0] tmr_q;
    logic [CNT_W-1:0] tmr_d;
`endif

    // Debounce: count cycles the synced input disagrees with the clean level.
    always_comb begin
      cnt_d   = '0;
      clean_d = clean_q;
      if (s[i] != clean_q) begin
        if (cnt_q == DEB_LAST) begin
          clean_d = s[i];
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    end

    // Event FSM follows the next clean level so evt rises with level.
    always_comb begin
      st_d = st_q;
      fire = 1'b0;
`ifdef TETRIS_INPUT_REPEAT_EN
      tmr_d = '0;
`endif
      if (!clean_d) begin
        st_d = IDLE;
      end else begin
        unique case (st_q)
          IDLE: begin
            fire = 1'b1;
`ifdef TETRIS_INPUT_REPEAT_EN
            st_d = REPEAT_MASK[i] ? DELAY : HOLD;
`else
            st_d = HOLD;
`endif
          end
`ifdef TETRIS_INPUT_REPEAT_EN
          DELAY: begin
            if (tmr_q == RD_LAST) begin
              fire = 1'b1;
              st_d = REPEAT;
            end else begin
              tmr_d = tmr_q + ONE;
            end
          end
          REPEAT: begin
            if (tmr_q == RR_LAST) begin
              fire = 1'b1;
            end else begin
              tmr_d = tmr_q + ONE;
            end
          end
`endif
          HOLD: st_d = HOLD;
          default: st_d = IDLE;
        endcase
      end
    end

    // Sticky flags: a fire beats a same-cycle ack, an ack clears both.
    always_comb begin
      evt_d  = evt_q;
      lost_d = lost_q;
      if (fire) begin
        evt_d  = 1'b1;
        lost_d = bus.ack[i] ? 1'b0 : (lost_q | evt_q);
      end else if (bus.ack[i]) begin
        evt_d  = 1'b0;
        lost_d = 1'b0;
      end
    end

    // Per-button state registers.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt_q   <= '0;
        clean_q <= 1'b0;
        st_q    <= IDLE;
        evt_q   <= 1'b0;
        lost_q  <= 1'b0;
`ifdef TETRIS_INPUT_REPEAT_EN
        tmr_q   <= '0;
`endif
      end else begin
        cnt_q   <= cnt_d;
        clean_q <= clean_d;
        st_q    <= st_d;
        evt_q   <= evt_d;
        lost_q  <= lost_d;
`ifdef TETRIS_INPUT_REPEAT_EN
        tmr_q   <= tmr_d;
`endif
      end
    end

    assign evt_v[i]   = evt_q;
    assign lost_v[i]  = lost_q;
    assign level_v[i] = clean_q;
  end

  assign bus.evt   = evt_v;
  assign bus.lost  = lost_v;
  assign bus.level = level_v;

endmodule

// File: tb/tb_tetris_input_conditioner.sv
// Bench for tetris_input_conditioner: directed scenarios plus random
// button/ack traffic, checked every cycle against a behavioural model.
module tb_tetris_input_conditioner;

  localparam int         DEB  = 4;
  localparam int         RD   = 10;
  localparam int         RR   = 3;
  localparam logic [3:0] MASK = 4'b0111;
`ifdef TETRIS_INPUT_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;

  tetris_input_conditioner_if bus ();

  tetris_input_conditioner #(
    .DEBOUNCE_CYCLES     (DEB),
    .REPEAT_DELAY_CYCLES (RD),
    .REPEAT_RATE_CYCLES  (RR),
    .REPEAT_MASK         (MASK),
    .CNT_W               (24)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [3:0] m_p1;
  logic [3:0] m_p2;
  logic [3:0] m_prev_s;
  logic [3:0] m_clean;
  logic [3:0] m_evt;
  logic [3:0] m_lost;
  int         m_run  [4];
  int         m_next [4];

  logic [3:0] prev_evt = 4'h0;
  int         rises  [4];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic bit rep_on(input int i);
    return REP && MASK[i];
  endfunction

  task automatic model_reset();
    m_p1     = 4'hF;
    m_p2     = 4'hF;
    m_prev_s = 4'h0;
    m_clean  = 4'h0;
    m_evt    = 4'h0;
    m_lost   = 4'h0;
    for (int i = 0; i < 4; i++) begin
      m_run[i]  = 0;
      m_next[i] = -1;
    end
  endtask

  // One clock edge of the reference: level changes after DEB equal samples,
  // events at press, press+RD, then every RR while held.
  task automatic model_step();
    logic [3:0] s;
    logic [3:0] nc;
    bit         fire;
    if (reset) begin
      model_reset();
      return;
    end
    cyc++;
    s  = ~m_p2;
    nc = m_clean;
    for (int i = 0; i < 4; i++) begin
      fire = 1'b0;
      if (s[i] == m_prev_s[i]) m_run[i]++;
      else m_run[i] = 1;
      if (s[i] != m_clean[i] && m_run[i] >= DEB) nc[i] = s[i];
      if (nc[i] && !m_clean[i]) begin
        fire = 1'b1;
        m_next[i] = rep_on(i) ? cyc + RD : -1;
      end else if (nc[i] && m_next[i] == cyc) begin
        fire = 1'b1;
        m_next[i] = cyc + RR;
      end
      if (!nc[i]) m_next[i] = -1;
      if (fire) begin
        if (bus.ack[i]) m_lost[i] = 1'b0;
        else if (m_evt[i]) m_lost[i] = 1'b1;
        m_evt[i] = 1'b1;
      end else if (bus.ack[i]) begin
        m_evt[i]  = 1'b0;
        m_lost[i] = 1'b0;
      end
    end
    m_prev_s = s;
    m_clean  = nc;
    m_p2     = m_p1;
    m_p1     = bus.btn_n;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_evt"},   32'(bus.evt),   32'(m_evt));
    chk({tag, "_lost"},  32'(bus.lost),  32'(m_lost));
    chk({tag, "_level"}, 32'(bus.level), 32'(m_clean));
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    compare_all("cyc");
    for (int i = 0; i < 4; i++)
      if (bus.evt[i] && !prev_evt[i]) rises[i]++;
    prev_evt = bus.evt;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clear_rises();
    for (int i = 0; i < 4; i++) rises[i] = 0;
  endtask

  task automatic release_all();
    bus.btn_n = 4'hF;
    ticks(8);
    bus.ack = 4'hF;
    tick();
    bus.ack = 4'h0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    bus.btn_n = 4'hF;
    bus.ack   = 4'h0;
    model_reset();
    clear_rises();
    #1;
    compare_all("rst");
    ticks(3);
    reset = 1'b0;

    // idle buttons produce nothing
    ticks(20);
    chk("idle_evt", 32'(bus.evt), 32'd0);

    // left press: level and evt after 2+DEB edges, lost at first repeat
    bus.btn_n[0] = 1'b0;
    ticks(5);
    chk("pre_level", 32'(bus.level[0]), 32'd0);
    tick();
    chk("press_level", 32'(bus.level[0]), 32'd1);
    chk("press_evt", 32'(bus.evt[0]), 32'd1);
    ticks(9);
    chk("lost_before", 32'(bus.lost[0]), 32'd0);
    tick();
    chk("lost_after", 32'(bus.lost[0]), 32'(REP));
    ticks(14);
    release_all();
    chk("rel_level", 32'(bus.level[0]), 32'd0);

    // left held with acks: press, +RD, +RR, ... until clean release
    clear_rises();
    bus.btn_n[0] = 1'b0;
    for (int k = 0; k < 23; k++) begin
      bus.ack[0] = bus.evt[0];
      tick();
    end
    chk("rep_count_held", 32'(rises[0]), REP ? 32'd4 : 32'd1);
    bus.btn_n[0] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      bus.ack[0] = bus.evt[0];
      tick();
    end
    bus.ack[0] = 1'b0;
    chk("rep_count_total", 32'(rises[0]), REP ? 32'd6 : 32'd1);

    // right glitches shorter than DEB are filtered
    clear_rises();
    bus.btn_n[1] = 1'b0; ticks(3);
    bus.btn_n[1] = 1'b1; ticks(1);
    bus.btn_n[1] = 1'b0; ticks(3);
    bus.btn_n[1] = 1'b1; ticks(8);
    chk("glitch_level", 32'(bus.level[1]), 32'd0);
    chk("glitch_evt", 32'(rises[1]), 32'd0);
    bus.btn_n[1] = 1'b0; ticks(4);
    bus.btn_n[1] = 1'b1; ticks(10);
    chk("short_press_evt", 32'(rises[1]), 32'd1);
    release_all();

    // rotate has no repeat; down repeat with same-cycle ack
    clear_rises();
    bus.btn_n[3] = 1'b0;
    ticks(40);
    chk("rot_count", 32'(rises[3]), 32'd1);
    chk("rot_lost", 32'(bus.lost[3]), 32'd0);
    release_all();
    bus.btn_n[2] = 1'b0;
    ticks(6);
    chk("down_evt", 32'(bus.evt[2]), 32'd1);
    ticks(9);
    bus.ack[2] = 1'b1;
    tick();
    bus.ack[2] = 1'b0;
    chk("fire_ack_evt", 32'(bus.evt[2]), 32'(REP));
    chk("fire_ack_lost", 32'(bus.lost[2]), 32'd0);
    release_all();

    // reset while left repeats; still held afterwards
    bus.btn_n[0] = 1'b0;
    ticks(20);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_rst_evt", 32'(bus.evt), 32'd0);
    chk("async_rst_lost", 32'(bus.lost), 32'd0);
    chk("async_rst_level", 32'(bus.level), 32'd0);
    ticks(3);
    reset = 1'b0;
    ticks(5);
    chk("post_rst_pre", 32'(bus.evt[0]), 32'd0);
    tick();
    chk("post_rst_evt", 32'(bus.evt[0]), 32'd1);
    bus.ack[0] = 1'b1;
    tick();
    bus.ack[0] = 1'b0;
    ticks(8);
    chk("post_rst_gap", 32'(bus.evt[0]), 32'd0);
    tick();
    chk("post_rst_rep", 32'(bus.evt[0]), 32'(REP));
    release_all();

    // random traffic
    for (int k = 0; k < 900; k++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 15) == 0) bus.btn_n[i] = ~bus.btn_n[i];
        bus.ack[i] = ($urandom_range(0, 4) == 0);
      end
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        #1;
        model_reset();
        compare_all("rnd_rst");
        ticks(2);
        reset = 1'b0;
      end
      tick();
    end
    bus.ack = 4'h0;
    release_all();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
